// File: rtl/cdb_arbiter_n.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_n : writeback arbiter between the FU result buffers and the
// NUM_CDB common data buses.
//
// FU i belongs to lane (i mod NUM_CDB). Each lane picks one result per cycle:
// category priority BEQ > MULT > LS > ALU, round-robin inside a category.
// A per-lane, per-category age counter promotes a category that has been
// requesting but denied for STARVE_LIMIT consecutive cycles (0 disables).
//
// Ports
//   clock           in   system clock
//   reset           in   asynchronous active-low reset
//   stall           in   1 = no grants this cycle, all state held
//   fu_result_valid in   [FU_SIZE]   FU i holds a completed result
//   fu_grant        out  [FU_SIZE]   FU i's result is consumed this cycle
//   cdb_valid       out  [NUM_CDB]   lane carries a result
//   cdb_fu_num      out  [NUM_CDB*FU_NUM_W] granted FU index, lane k at k*FU_NUM_W
//   cdb_cat_select  out  [NUM_CDB*4] one-hot category (0 ALU,1 LS,2 MULT,3 BEQ)
// -----------------------------------------------------------------------------

// One arbitration lane. Its valid/grant vectors are lane-local: local bit l
// is FU (LANE + l*NUM_CDB). Because every category count is a multiple of
// NUM_CDB, each category occupies a contiguous range of local bits.
module cdb_arbiter_lane #(
    parameter int NUM_CDB      = 2,
    parameter int LANE         = 0,
    parameter int NUM_ALU      = 8,
    parameter int NUM_LS       = 4,
    parameter int NUM_MULT     = 4,
    parameter int NUM_BEQ      = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int FU_NUM_W     = 5,
    parameter int LANE_FUS     = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic [LANE_FUS-1:0] i_valid,
    output logic [LANE_FUS-1:0] o_grant,
    output logic                o_valid,
    output logic [FU_NUM_W-1:0] o_fu_num,
    output logic [3:0]          o_cat
);
    localparam int MEM_ALU  = NUM_ALU  / NUM_CDB;
    localparam int MEM_LS   = NUM_LS   / NUM_CDB;
    localparam int MEM_MULT = NUM_MULT / NUM_CDB;
    localparam int MEM_BEQ  = NUM_BEQ  / NUM_CDB;
    localparam int MEM [4]  = '{MEM_ALU, MEM_LS, MEM_MULT, MEM_BEQ};
    localparam int LB  [4]  = '{0, MEM_ALU, MEM_ALU + MEM_LS, MEM_ALU + MEM_LS + MEM_MULT};
    localparam int MAX_AL   = (MEM_ALU  > MEM_LS)  ? MEM_ALU  : MEM_LS;
    localparam int MAX_MB   = (MEM_MULT > MEM_BEQ) ? MEM_MULT : MEM_BEQ;
    localparam int MAXM     = (MAX_AL   > MAX_MB)  ? MAX_AL   : MAX_MB;
    localparam int PTR_W    = (MAXM > 1) ? $clog2(MAXM) : 1;
    localparam int AGE_W    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    logic [3:0][PTR_W-1:0] r_ptr;
    logic [3:0][AGE_W-1:0] r_age;

    logic [3:0][MAXM-1:0]  w_mem;
    logic [3:0]            w_req;
    logic [3:0][PTR_W-1:0] w_pos;
    logic [3:0]            w_starved;
    logic [3:0]            w_pick;
    logic [3:0]            w_cat;
    logic                  w_go;

    // Category member table, padded with zeros up to MAXM.
    for (genvar c = 0; c < 4; c++) begin : g_cat
        for (genvar j = 0; j < MAXM; j++) begin : g_mem
            if (j < MEM[c]) begin : g_real
                assign w_mem[c][j] = i_valid[LB[c] + j];
                assign o_grant[LB[c] + j] = w_go & w_cat[c] & (w_pos[c] == PTR_W'(j));
            end else begin : g_pad
                assign w_mem[c][j] = 1'b0;
            end
        end
    end

    // Round-robin search as two passes: members at/after the pointer first,
    // then the wrapped members below it. A category requests iff a hit exists.
    always_comb begin
        w_req = '0;
        w_pos = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < MAXM; j++) begin
                if (!w_req[c] && w_mem[c][j] && j >= int'(r_ptr[c])) begin
                    w_req[c] = 1'b1;
                    w_pos[c] = PTR_W'(j);
                end
            end
            for (int j = 0; j < MAXM; j++) begin
                if (!w_req[c] && w_mem[c][j] && j < int'(r_ptr[c])) begin
                    w_req[c] = 1'b1;
                    w_pos[c] = PTR_W'(j);
                end
            end
        end
    end

    // Starved categories override plain requests; fixed priority in both sets.
    always_comb begin
        for (int c = 0; c < 4; c++)
            w_starved[c] = (STARVE_LIMIT != 0) && w_req[c] && (r_age[c] == AGE_MAX);
        w_pick = (|w_starved) ? w_starved : w_req;
        if      (w_pick[3]) w_cat = 4'b1000;
        else if (w_pick[2]) w_cat = 4'b0100;
        else if (w_pick[1]) w_cat = 4'b0010;
        else if (w_pick[0]) w_cat = 4'b0001;
        else                w_cat = 4'b0000;
    end

    assign w_go = reset & ~stall & (|w_req);

    always_comb begin
        o_valid  = w_go;
        o_cat    = w_go ? w_cat : 4'b0000;
        o_fu_num = '0;
        for (int c = 0; c < 4; c++)
            if (w_go && w_cat[c])
                o_fu_num = FU_NUM_W'(LANE + (LB[c] + int'(w_pos[c])) * NUM_CDB);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
            r_age <= '0;
        end else if (!stall) begin
            for (int c = 0; c < 4; c++) begin
                if (w_go && w_cat[c]) begin
                    r_ptr[c] <= (int'(w_pos[c]) == MEM[c] - 1) ? '0 : w_pos[c] + PTR_W'(1);
                    r_age[c] <= '0;
                end else if (!w_req[c]) begin
                    r_age[c] <= '0;
                end else if (r_age[c] != AGE_MAX) begin
                    r_age[c] <= r_age[c] + AGE_W'(1);
                end
            end
        end
    end
endmodule

module cdb_arbiter_n #(
    parameter  int NUM_CDB      = 2,
    parameter  int NUM_ALU      = 8,
    parameter  int NUM_LS       = 4,
    parameter  int NUM_MULT     = 4,
    parameter  int NUM_BEQ      = 4,
    parameter  int STARVE_LIMIT = 4,
    localparam int FU_SIZE      = NUM_ALU + NUM_LS + NUM_MULT + NUM_BEQ,
    localparam int FU_CAT       = 4,
    localparam int FU_NUM_W     = $clog2(FU_SIZE)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          stall,
    input  logic [FU_SIZE-1:0]            fu_result_valid,
    output logic [FU_SIZE-1:0]            fu_grant,
    output logic [NUM_CDB-1:0]            cdb_valid,
    output logic [NUM_CDB*FU_NUM_W-1:0]   cdb_fu_num,
    output logic [NUM_CDB*FU_CAT-1:0]     cdb_cat_select
);
    localparam int LANE_FUS = FU_SIZE / NUM_CDB;

    if ((NUM_ALU % NUM_CDB) != 0 || (NUM_LS % NUM_CDB) != 0 ||
        (NUM_MULT % NUM_CDB) != 0 || (NUM_BEQ % NUM_CDB) != 0) begin : g_bad_cfg
        $error("cdb_arbiter_n: every category count must be a multiple of NUM_CDB");
    end

    logic [NUM_CDB-1:0][FU_NUM_W-1:0] w_fu_num;
    logic [NUM_CDB-1:0][FU_CAT-1:0]   w_cat;

    for (genvar k = 0; k < NUM_CDB; k++) begin : g_lane
        logic [LANE_FUS-1:0] w_lvalid;
        logic [LANE_FUS-1:0] w_lgrant;

        // Interleaved mapping: local bit l is FU k + l*NUM_CDB.
        for (genvar l = 0; l < LANE_FUS; l++) begin : g_map
            assign w_lvalid[l]               = fu_result_valid[k + l * NUM_CDB];
            assign fu_grant[k + l * NUM_CDB] = w_lgrant[l];
        end

        cdb_arbiter_lane #(
            .NUM_CDB     (NUM_CDB),
            .LANE        (k),
            .NUM_ALU     (NUM_ALU),
            .NUM_LS      (NUM_LS),
            .NUM_MULT    (NUM_MULT),
            .NUM_BEQ     (NUM_BEQ),
            .STARVE_LIMIT(STARVE_LIMIT),
            .FU_NUM_W    (FU_NUM_W),
            .LANE_FUS    (LANE_FUS)
        ) u_lane (
            .clock   (clock),
            .reset   (reset),
            .stall   (stall),
            .i_valid (w_lvalid),
            .o_grant (w_lgrant),
            .o_valid (cdb_valid[k]),
            .o_fu_num(w_fu_num[k]),
            .o_cat   (w_cat[k])
        );
    end

    assign cdb_fu_num     = w_fu_num;
    assign cdb_cat_select = w_cat;
endmodule

// File: tb/tb_cdb_arbiter_n.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter_n : self-checking bench for cdb_arbiter_n. Two instances share
// the inputs: dut4 (STARVE_LIMIT=4) and dut0 (aging disabled). A behavioural
// model keeps per-lane member lists, pointers and ages as plain integers.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter_n;
    localparam int CNT  [4] = '{8, 4, 4, 4};
    localparam int BASE [4] = '{0, 8, 12, 16};

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic [19:0] fu_result_valid;

    logic [19:0] g4, g0;
    logic [1:0]  v4, v0;
    logic [9:0]  n4, n0;
    logic [7:0]  c4, c0;
    logic [39:0] act4, act0;

    always #5 clock = ~clock;

    cdb_arbiter_n #(.STARVE_LIMIT(4)) dut4 (
        .clock(clock), .reset(reset), .stall(stall), .fu_result_valid(fu_result_valid),
        .fu_grant(g4), .cdb_valid(v4), .cdb_fu_num(n4), .cdb_cat_select(c4));

    cdb_arbiter_n #(.STARVE_LIMIT(0)) dut0 (
        .clock(clock), .reset(reset), .stall(stall), .fu_result_valid(fu_result_valid),
        .fu_grant(g0), .cdb_valid(v0), .cdb_fu_num(n0), .cdb_cat_select(c0));

    assign act4 = {g4, v4, n4, c4};
    assign act0 = {g0, v0, n0, c0};

    int n_cmp = 0;
    int n_bad = 0;

    // Model state, index [dut][lane][category]; dut 0 -> limit 4, dut 1 -> limit 0.
    int          m_ptr [2][2][4];
    int          m_age [2][2][4];
    int          m_req [2][2][4];
    int          m_sel [2][2];
    int          m_pos [2][2];
    logic [39:0] exp_out [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < 4; c++) begin
                    m_ptr[d][k][c] = 0;
                    m_age[d][k][c] = 0;
                end
    endtask

    task automatic model_eval();
        for (int d = 0; d < 2; d++) begin
            int lim;
            logic [19:0]     g;
            logic [1:0]      v;
            logic [1:0][4:0] nn;
            logic [1:0][3:0] cc;
            lim = (d == 0) ? 4 : 0;
            g = '0; v = '0; nn = '0; cc = '0;
            for (int k = 0; k < 2; k++) begin
                m_sel[d][k] = -1;
                m_pos[d][k] = -1;
                for (int c = 0; c < 4; c++) begin
                    m_req[d][k][c] = 0;
                    for (int j = 0; j < CNT[c] / 2; j++)
                        if (fu_result_valid[5'(BASE[c] + k + 2 * j)]) m_req[d][k][c] = 1;
                end
                if (reset && !stall) begin
                    for (int c = 3; c >= 0; c--)
                        if (lim != 0 && m_req[d][k][c] != 0 && m_age[d][k][c] == lim && m_sel[d][k] < 0)
                            m_sel[d][k] = c;
                    for (int c = 3; c >= 0; c--)
                        if (m_req[d][k][c] != 0 && m_sel[d][k] < 0) m_sel[d][k] = c;
                    if (m_sel[d][k] >= 0) begin
                        int c, m, fu, jj;
                        c = m_sel[d][k];
                        m = CNT[c] / 2;
                        for (int off = 0; off < m; off++) begin
                            jj = (m_ptr[d][k][c] + off) % m;
                            if (m_pos[d][k] < 0 && fu_result_valid[5'(BASE[c] + k + 2 * jj)])
                                m_pos[d][k] = jj;
                        end
                        fu = BASE[c] + k + 2 * m_pos[d][k];
                        g[5'(fu)] = 1'b1;
                        v[1'(k)]  = 1'b1;
                        nn[1'(k)] = 5'(fu);
                        cc[1'(k)] = 4'(1 << c);
                    end
                end
            end
            exp_out[d] = {g, v, nn, cc};
        end
    endtask

    task automatic model_update();
        if (reset && !stall) begin
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < 2; k++)
                    for (int c = 0; c < 4; c++) begin
                        int lim;
                        lim = (d == 0) ? 4 : 0;
                        if (m_sel[d][k] == c) begin
                            m_ptr[d][k][c] = (m_pos[d][k] + 1) % (CNT[c] / 2);
                            m_age[d][k][c] = 0;
                        end else if (m_req[d][k][c] == 0) begin
                            m_age[d][k][c] = 0;
                        end else if (m_age[d][k][c] < lim) begin
                            m_age[d][k][c] = m_age[d][k][c] + 1;
                        end
                    end
        end
    endtask

    task automatic step(input logic [19:0] v, input logic st);
        fu_result_valid = v;
        stall = st;
        @(negedge clock);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; fu_result_valid = 20'hFFFFF;
        model_reset();
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({act4, act0} !== 80'b0) begin
            n_bad++; $display("FAIL reset_hold: got %h want 0", {act4, act0});
        end
        @(posedge clock); #1;
        reset = 1'b1;
        step(20'hFFFFF, 1'b0);
        n_cmp++;
        if ({act4, act0} !== {exp_out[0], exp_out[1]}) begin
            n_bad++; $display("FAIL reset_first_model: got %h want %h", {act4, act0}, {exp_out[0], exp_out[1]});
        end
        n_cmp++;
        if ({g4, v4, n4, c4} !== {20'h30000, 2'b11, 5'd17, 5'd16, 8'b1000_1000}) begin
            n_bad++; $display("FAIL reset_first_grant: got %h want %h", {g4, v4, n4, c4},
                              {20'h30000, 2'b11, 5'd17, 5'd16, 8'b1000_1000});
        end
        tick();
    endtask

    task automatic test_priority();
        step(20'h11105, 1'b0);
        n_cmp++;
        if ({act4, act0} !== {exp_out[0], exp_out[1]}) begin
            n_bad++; $display("FAIL prio_beq_model: got %h want %h", {act4, act0}, {exp_out[0], exp_out[1]});
        end
        n_cmp++;
        if ({v4, n4[4:0], c4[3:0], g4} !== {2'b01, 5'd16, 4'b1000, 20'h10000}) begin
            n_bad++; $display("FAIL prio_beq: got %h want %h", {v4, n4[4:0], c4[3:0], g4},
                              {2'b01, 5'd16, 4'b1000, 20'h10000});
        end
        tick();
        step(20'h01105, 1'b0);
        n_cmp++;
        if ({act4, act0} !== {exp_out[0], exp_out[1]}) begin
            n_bad++; $display("FAIL prio_mult_model: got %h want %h", {act4, act0}, {exp_out[0], exp_out[1]});
        end
        n_cmp++;
        if ({v4, n4[4:0], c4[3:0]} !== {2'b01, 5'd12, 4'b0100}) begin
            n_bad++; $display("FAIL prio_mult: got %h want %h", {v4, n4[4:0], c4[3:0]}, {2'b01, 5'd12, 4'b0100});
        end
        tick();
    endtask

    task automatic test_round_robin();
        int seq [5] = '{0, 2, 4, 6, 0};
        for (int i = 0; i < 5; i++) begin
            step(20'h00055, 1'b0);
            n_cmp++;
            if ({act4, act0} !== {exp_out[0], exp_out[1]}) begin
                n_bad++; $display("FAIL rr_model[%0d]: got %h want %h", i, {act4, act0}, {exp_out[0], exp_out[1]});
            end
            n_cmp++;
            if (n0[4:0] !== 5'(seq[i])) begin
                n_bad++; $display("FAIL rr_seq[%0d]: got %0d want %0d", i, n0[4:0], seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        step(20'h00055, 1'b0);
        n_cmp++;
        if (n0[4:0] !== 5'd2 || n4[4:0] !== 5'd2) begin
            n_bad++; $display("FAIL stall_pre: got %0d/%0d want 2", n4[4:0], n0[4:0]);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            step(20'h00055, 1'b1);
            n_cmp++;
            if ({g4, g0, v4, v0, n4, n0, c4, c0} !== 64'b0) begin
                n_bad++; $display("FAIL stall_quiet[%0d]: got %h want 0", i, {g4, g0, v4, v0, n4, n0, c4, c0});
            end
            tick();
        end
        step(20'h00055, 1'b0);
        n_cmp++;
        if (n0[4:0] !== 5'd4 || n4[4:0] !== 5'd4 || g4 !== 20'h00010) begin
            n_bad++; $display("FAIL stall_resume: got %0d/%0d g=%h want 4 g=00010", n4[4:0], n0[4:0], g4);
        end
        tick();
    endtask

    task automatic test_starvation();
        int seq [10] = '{16, 16, 16, 16, 0, 16, 16, 16, 16, 0};
        for (int i = 0; i < 10; i++) begin
            step(20'h10001, 1'b0);
            n_cmp++;
            if ({act4, act0} !== {exp_out[0], exp_out[1]}) begin
                n_bad++; $display("FAIL starve_model[%0d]: got %h want %h", i, {act4, act0}, {exp_out[0], exp_out[1]});
            end
            n_cmp++;
            if (n4[4:0] !== 5'(seq[i]) || n0[4:0] !== 5'd16) begin
                n_bad++; $display("FAIL starve_seq[%0d]: got %0d/%0d want %0d/16", i, n4[4:0], n0[4:0], seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        // Walk dut4 lane0 ALU pointer to 2 and its age to 3 before resetting.
        step(20'h00005, 1'b0);
        n_cmp++;
        if (n4[4:0] !== 5'd2) begin
            n_bad++; $display("FAIL rmid_setup: got %0d want 2", n4[4:0]);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            step(20'h10010, 1'b0);
            n_cmp++;
            if ({act4, act0} !== {exp_out[0], exp_out[1]}) begin
                n_bad++; $display("FAIL rmid_age[%0d]: got %h want %h", i, {act4, act0}, {exp_out[0], exp_out[1]});
            end
            tick();
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({act4, act0} !== 80'b0) begin
            n_bad++; $display("FAIL rmid_drop: got %h want 0", {act4, act0});
        end
        model_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        step(20'h00055, 1'b0);
        n_cmp++;
        if (n4[4:0] !== 5'd0 || n0[4:0] !== 5'd0 || g4 !== 20'h00001 || {act4, act0} !== {exp_out[0], exp_out[1]}) begin
            n_bad++; $display("FAIL rmid_first: got %h want %h", {act4, act0}, {exp_out[0], exp_out[1]});
        end
        tick();
    endtask

    task automatic test_random();
        logic [19:0] v, keep, g;
        logic        st;
        v = 20'($urandom());
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 7) == 0);
            step(v, st);
            n_cmp++;
            if ({act4, act0} !== {exp_out[0], exp_out[1]}) begin
                n_bad++; $display("FAIL random[%0d]: v=%h st=%0d got %h want %h", i, v, st,
                                  {act4, act0}, {exp_out[0], exp_out[1]});
            end
            tick();
            // FUs hold until granted; granted or idle FUs may present anything.
            g = exp_out[0][39:20];
            keep = v & ~g;
            v = keep | (20'($urandom()) & 20'($urandom() | $urandom()) & ~keep);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_round_robin();
        test_stall();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter_n.md
Name: cdb_arbiter_n

Overview:
- Parametrised writeback arbiter between the FU result buffers and the NUM_CDB common data buses; successor to the fixed 2-lane, 20-FU selector.
- Each lane serves a fixed, interleaved subset of FUs and picks one result per cycle.
- Category priority is BEQ > MULT > LS > ALU, with round-robin within a category.
- New behaviour: a per-lane starvation-aging promotion, a stall input, and an explicit per-FU grant handshake.

Parameters:
- NUM_CDB, 2, number of CDB lanes; FU i belongs to lane (i mod NUM_CDB).
- NUM_ALU, 8, ALU count; FU indices [0, NUM_ALU).
- NUM_LS, 4, LS count; indices follow the ALUs.
- NUM_MULT, 4, MULT count; indices follow the LS units.
- NUM_BEQ, 4, BEQ count; indices follow the MULTs.
- STARVE_LIMIT, 4, number of consecutive denied cycles before a category is promoted; 0 disables aging.
- Derived, not overridable: FU_SIZE = sum of the four counts (20); FU_CAT = 4; FU_NUM_W = $clog2(FU_SIZE) (5).
- Constraint: each category count is a multiple of NUM_CDB; elaboration fails otherwise.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  1 = no grants this cycle; all state held.
- fu_result_valid  in  FU_SIZE  bit i = FU i holds a completed result.
- fu_grant  out  FU_SIZE  bit i = FU i's result is taken this cycle.
- cdb_valid  out  NUM_CDB  lane carries a result.
- cdb_fu_num  out  NUM_CDB*FU_NUM_W  granted FU index per lane; lane k uses bits [k*FU_NUM_W +: FU_NUM_W].
- cdb_cat_select  out  NUM_CDB*FU_CAT  one-hot category per lane: bit0 ALU, bit1 LS, bit2 MULT, bit3 BEQ.

Behaviour:
- Timing: all outputs are combinational from fu_result_valid, stall and registered state (zero latency). State updates on posedge clock.
- Reset: while reset==0, all outputs are forced to 0. All RR pointers and age counters clear to 0 asynchronously.
- Handshake:
  - An FU holds its valid bit until it sees fu_grant high in a cycle.
  - The grant is the consume strobe. Next cycle the FU drops valid or presents a new result.
  - The arbiter never grants an FU whose valid bit is 0.
- Per lane k, each cycle:
  1. Requesting categories = categories with at least one valid FU in lane k.
  2. Starved categories = requesting categories with age == STARVE_LIMIT (only when STARVE_LIMIT != 0).
  3. If any category is starved, pick the highest-fixed-priority starved one. Otherwise pick the highest-priority requesting one.
  4. Within the chosen category, grant the first valid member at or after rr_ptr[k][cat], with wrap-around. Members are ordered by ascending FU index within the lane.
  5. Drive cdb_valid[k]=1, cdb_fu_num = FU index, cdb_cat_select = one-hot category.
  6. If there are no requests, or stall==1: cdb_valid[k]=0, cdb_fu_num=0, cdb_cat_select=0, and no fu_grant bits in the lane.
- Each lane grants at most one FU per cycle. Lanes are independent and run in parallel.
- RR pointers (width $clog2(members per lane), minimum 1 bit):
  - On a grant: rr_ptr[k][cat] <= granted member position + 1, wrapping to 0 after the last member.
  - Other categories' pointers hold.
  - The pointer is used only for the search start, so a stale pointer is harmless.
- Age counters (per lane, per category; width $clog2(STARVE_LIMIT+1)), updated when stall==0:
  - Category requesting but not granted: increment, saturating at STARVE_LIMIT.
  - Category granted, or not requesting: clear to 0.
  - When stall==1: all ages hold.
- Promotion lasts until the starved category is granted; its age then returns to 0.
- Simultaneous events: a request arriving the same cycle a category is granted does not count toward age.

Test Plan:
- Reset: hold reset=0 with fu_result_valid=all 1 → fu_grant=0, cdb_valid=0. Release → the first cycle grants FU16 on lane0 and FU17 on lane1, cat_select=4'b1000 on each.
- Priority: valid bits {0,2,8,12,16} → lane0 grants 16 (4'b1000), lane1 cdb_valid=0. Drop 16 → grants 12 (4'b0100).
- Round-robin: valid bits {0,2,4,6} held constantly, STARVE_LIMIT=0 → lane0 grants 0,2,4,6,0 on consecutive cycles.
- Starvation: STARVE_LIMIT=4, valid bits {0,16} held → lane0 grant sequence 16,16,16,16,0,16,16,16,16,0. With STARVE_LIMIT=0 → always 16.
- Stall: mid round-robin sequence (next grant 4), assert stall for 3 cycles → no grants, ages frozen. Deassert → grants resume at 4.
- Reset mid-operation: assert reset with rr_ptr[0][ALU]=2 and age=3 → outputs drop immediately. After release with {0,2,4,6} valid → first grant is 0.
